mem_access: RTL and testbench

Memory-access stage directly downstream of the combinational execute stage. Registers the execute result (`waddr`/`wdata`/`we`) together with a memory request, performs single-word loads and stores over a simple request/acknowledge data bus, and presents the final register-write triple to write-back. While a bus access is outstanding it raises a stall request so the upstream stages hold their outputs.

---
 rtl/mem_access.sv | 197 +++++++++++++++++++
 tb/tb_mem_access.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: registers execute results, runs single-word bus loads/stores
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
  parameter int DATA_W         = 16,
  parameter int RADDR_W        = 4,
  parameter int MADDR_W        = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic               we_i,
  input  logic [1:0]         mem_op_i,
  input  logic [MADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0]  mem_sdata_i,
  output logic [RADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               we_o,
  output logic               stall_req_o,
  output logic               err_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [MADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0]  bus_wdata_o,
  input  logic [DATA_W-1:0]  bus_rdata_i,
  input  logic               bus_ack_i
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  state_t               state_q, state_d;
  logic [RADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [MADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]    bus_wdata_q, bus_wdata_d;
  logic [RADDR_W-1:0]   lat_waddr_q, lat_waddr_d;
  logic                 lat_we_q, lat_we_d;
  logic                 lat_load_q, lat_load_d;
  // An ALU op accepted in the same edge as a load completion is parked here for one cycle.
  logic                 pend_q, pend_d;
  logic [RADDR_W-1:0]   pend_waddr_q, pend_waddr_d;
  logic [DATA_W-1:0]    pend_wdata_q, pend_wdata_d;
  logic                 pend_we_q, pend_we_d;
  logic                 stall;
  logic                 slot_used;
  logic                 is_mem;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  assign stall  = (state_q == BUSY) && !bus_ack_i;
  assign is_mem = (mem_op_i == OP_LOAD) || (mem_op_i == OP_STORE);

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    err_d        = 1'b0;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    lat_waddr_d  = lat_waddr_q;
    lat_we_d     = lat_we_q;
    lat_load_d   = lat_load_q;
    pend_d       = pend_q;
    pend_waddr_d = pend_waddr_q;
    pend_wdata_d = pend_wdata_q;
    pend_we_d    = pend_we_q;
    slot_used    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    if (state_q == BUSY) begin
      slot_used = 1'b1;
      if (bus_ack_i) begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
        if (lat_load_q) begin
          waddr_d = lat_waddr_q;
          wdata_d = bus_rdata_i;
          we_d    = lat_we_q;
        end
      end
`ifdef MEM_TIMEOUT_EN
      else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
        err_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end else if (pend_q) begin
      slot_used = 1'b1;
      waddr_d   = pend_waddr_q;
      wdata_d   = pend_wdata_q;
      we_d      = pend_we_q;
      pend_d    = 1'b0;
    end

    if (valid_i && !stall) begin
      if (is_mem) begin
        state_d     = BUSY;
        bus_req_d   = 1'b1;
        bus_we_d    = (mem_op_i == OP_STORE);
        bus_addr_d  = mem_addr_i;
        bus_wdata_d = mem_sdata_i;
        lat_waddr_d = waddr_i;
        lat_we_d    = we_i;
        lat_load_d  = (mem_op_i == OP_LOAD);
`ifdef MEM_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end else if (slot_used) begin
        pend_d       = 1'b1;
        pend_waddr_d = waddr_i;
        pend_wdata_d = wdata_i;
        pend_we_d    = we_i;
      end else begin
        waddr_d = waddr_i;
        wdata_d = wdata_i;
        we_d    = we_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      waddr_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      lat_waddr_q  <= '0;
      lat_we_q     <= 1'b0;
      lat_load_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_waddr_q <= '0;
      pend_wdata_q <= '0;
      pend_we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      err_q        <= err_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      lat_waddr_q  <= lat_waddr_d;
      lat_we_q     <= lat_we_d;
      lat_load_q   <= lat_load_d;
      pend_q       <= pend_d;
      pend_waddr_q <= pend_waddr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_we_q    <= pend_we_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign we_o        = we_q;
  assign err_o       = err_q;
  assign stall_req_o = stall;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access (timeout scenario follows MEM_TIMEOUT_EN)
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  waddr_i;
  logic [15:0] wdata_i;
  logic        we_i;
  logic [1:0]  mem_op_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_sdata_i;
  logic [3:0]  waddr_o;
  logic [15:0] wdata_o;
  logic        we_o;
  logic        stall_req_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [15:0] bus_addr_o;
  logic [15:0] bus_wdata_o;
  logic [15:0] bus_rdata_i;
  logic        bus_ack_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } ret_t;

  ret_t exp_q[$];

  mem_access #(
    .DATA_W(16), .RADDR_W(4), .MADDR_W(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .we_i(we_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o), .stall_req_o(stall_req_o),
    .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  task automatic present(input logic [1:0] op, input logic [3:0] wa, input logic [15:0] wd,
                         input logic we, input logic [15:0] ma, input logic [15:0] sd);
    valid_i = 1'b1; mem_op_i = op; waddr_i = wa; wdata_i = wd; we_i = we;
    mem_addr_i = ma; mem_sdata_i = sd;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    present(2'b00, 4'd0, 16'd0, 1'b0, 16'd0, 16'd0);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({waddr_o, wdata_o, we_o, stall_req_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got waddr=%h wdata=%h we=%b stall=%b err=%b req=%b bwe=%b baddr=%h bwdata=%h, expected all zero",
               waddr_o, wdata_o, we_o, stall_req_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    present(2'b00, 4'd3, 16'h1234, 1'b1, 16'h0, 16'h0);
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin errors++; $display("FAIL alu_stall_pre: got %b expected 0", stall_req_o); end
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if ({we_o, waddr_o, wdata_o, stall_req_o} !== {1'b1, 4'd3, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL alu_retire: got we=%b waddr=%h wdata=%h stall=%b expected 1/3/1234/0", we_o, waddr_o, wdata_o, stall_req_o);
    end
    @(negedge clk);
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b0, 4'd3, 16'h1234}) begin
      errors++;
      $display("FAIL alu_hold: got we=%b waddr=%h wdata=%h expected 0/3/1234", we_o, waddr_o, wdata_o);
    end
  endtask

  task automatic test_load();
    logic [15:0] addr;
    int stall_cnt;
    addr = 16'($urandom);
    stall_cnt = 0;
    present(2'b01, 4'd5, 16'h7777, 1'b1, addr, 16'h0);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, we_o} !== {1'b1, 1'b0, addr, 1'b0}) begin
      errors++;
      $display("FAIL load_request: got req=%b bwe=%b addr=%h we=%b expected 1/0/%h/0", bus_req_o, bus_we_o, bus_addr_o, we_o, addr);
    end
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (stall_req_o === 1'b1) stall_cnt++;
    end
    @(negedge clk);
    bus_ack_i = 1'b1; bus_rdata_i = 16'hBEEF;
    #1;
    if (stall_req_o === 1'b1) stall_cnt++;
    checks++;
    if (stall_cnt !== 2) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 2", stall_cnt); end
    @(negedge clk);
    bus_ack_i = 1'b0;
    checks++;
    if ({we_o, waddr_o, wdata_o, bus_req_o} !== {1'b1, 4'd5, 16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL load_retire: got we=%b waddr=%h wdata=%h req=%b expected 1/5/beef/0", we_o, waddr_o, wdata_o, bus_req_o);
    end
  endtask

  task automatic test_store();
    present(2'b10, 4'd6, 16'($urandom), 1'b1, 16'h0040, 16'h00AA);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, we_o} !== {1'b1, 1'b1, 16'h0040, 16'h00AA, 1'b0}) begin
      errors++;
      $display("FAIL store_request: got req=%b bwe=%b addr=%h data=%h we=%b expected 1/1/0040/00aa/0",
               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, we_o);
    end
    bus_ack_i = 1'b1;
    #1;
    checks++;
    if (stall_req_o !== 1'b0) begin errors++; $display("FAIL store_stall_ack: got %b expected 0", stall_req_o); end
    @(negedge clk);
    bus_ack_i = 1'b0;
    checks++;
    if ({bus_req_o, we_o} !== 2'b00) begin
      errors++;
      $display("FAIL store_done: got req=%b we=%b expected 0/0", bus_req_o, we_o);
    end
    @(negedge clk);
    checks++;
    if (we_o !== 1'b0) begin errors++; $display("FAIL store_no_wb: got we=%b expected 0", we_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, wd;
    rd = 16'($urandom); wd = 16'($urandom);
    present(2'b01, 4'd7, 16'h0, 1'b1, 16'h0100, 16'h0);
    @(negedge clk);
    bus_ack_i = 1'b1; bus_rdata_i = rd;
    present(2'b00, 4'd9, wd, 1'b1, 16'h0, 16'h0);
    @(negedge clk);
    bus_ack_i = 1'b0; valid_i = 1'b0;
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 4'd7, rd}) begin
      errors++;
      $display("FAIL b2b_load: got we=%b waddr=%h wdata=%h expected 1/7/%h", we_o, waddr_o, wdata_o, rd);
    end
    @(negedge clk);
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 4'd9, wd}) begin
      errors++;
      $display("FAIL b2b_alu: got we=%b waddr=%h wdata=%h expected 1/9/%h", we_o, waddr_o, wdata_o, wd);
    end
    @(negedge clk);
    checks++;
    if (we_o !== 1'b0) begin errors++; $display("FAIL b2b_end: got we=%b expected 0", we_o); end
  endtask

  task automatic test_reset_busy();
    present(2'b01, 4'd2, 16'h0, 1'b1, 16'h0200, 16'h0);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({waddr_o, wdata_o, we_o, stall_req_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_busy_outputs: got waddr=%h wdata=%h we=%b stall=%b req=%b addr=%h expected all zero",
               waddr_o, wdata_o, we_o, stall_req_o, bus_req_o, bus_addr_o);
    end
    bus_ack_i = 1'b1; bus_rdata_i = 16'h5A5A;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({we_o, bus_req_o, stall_req_o} !== 3'b000) begin
        errors++;
        $display("FAIL late_ack_ignored: got we=%b req=%b stall=%b expected 0/0/0", we_o, bus_req_o, stall_req_o);
      end
    end
    bus_ack_i = 1'b0;
  endtask

  task automatic test_random();
    logic        outstanding, cur_bwe, ack_now, exp_stall, is_load;
    logic [15:0] cur_addr, cur_sdata, cur_rdata;
    int          wait_left;
    ret_t        r;
    outstanding = 1'b0; cur_bwe = 1'b0; cur_addr = '0; cur_sdata = '0; cur_rdata = '0; wait_left = 0;
    for (int i = 0; i < 430; i++) begin
      @(negedge clk);
      if (we_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious_we: got we=1 waddr=%h wdata=%h expected no retirement", waddr_o, wdata_o);
        end else begin
          r = exp_q.pop_front();
          if ({waddr_o, wdata_o} !== {r.a, r.d}) begin
            errors++;
            $display("FAIL rand_retire: got waddr=%h wdata=%h expected %h/%h", waddr_o, wdata_o, r.a, r.d);
          end
        end
      end
      checks++;
      if (bus_req_o !== outstanding) begin
        errors++;
        $display("FAIL rand_bus_req: got %b expected %b", bus_req_o, outstanding);
      end
      ack_now = 1'b0;
      if (outstanding) begin
        checks++;
        if ({bus_we_o, bus_addr_o} !== {cur_bwe, cur_addr} || (cur_bwe && bus_wdata_o !== cur_sdata)) begin
          errors++;
          $display("FAIL rand_bus_fields: got we=%b addr=%h data=%h expected %b/%h/%h",
                   bus_we_o, bus_addr_o, bus_wdata_o, cur_bwe, cur_addr, cur_sdata);
        end
        if (wait_left == 0) begin
          ack_now = 1'b1; bus_rdata_i = cur_rdata;
        end else begin
          wait_left--; bus_rdata_i = 16'($urandom);
        end
        bus_ack_i = ack_now;
      end else begin
        bus_ack_i = ($urandom_range(0, 3) == 0);
        bus_rdata_i = 16'($urandom);
      end
      #1;
      exp_stall = outstanding && !ack_now;
      checks++;
      if (stall_req_o !== exp_stall) begin
        errors++;
        $display("FAIL rand_stall: got %b expected %b", stall_req_o, exp_stall);
      end
      if (ack_now) outstanding = 1'b0;
      if (!exp_stall) begin
        valid_i = (i < 400) && ($urandom_range(0, 3) != 0);
        mem_op_i = 2'($urandom); waddr_i = 4'($urandom); wdata_i = 16'($urandom);
        we_i = 1'($urandom); mem_addr_i = 16'($urandom); mem_sdata_i = 16'($urandom);
        if (valid_i) begin
          if (mem_op_i == 2'b01 || mem_op_i == 2'b10) begin
            is_load = (mem_op_i == 2'b01);
            outstanding = 1'b1; cur_bwe = !is_load; cur_addr = mem_addr_i; cur_sdata = mem_sdata_i;
            cur_rdata = 16'($urandom); wait_left = $urandom_range(0, 3);
            if (is_load && we_i) exp_q.push_back('{a: waddr_i, d: cur_rdata});
          end else if (we_i) begin
            exp_q.push_back('{a: waddr_i, d: wdata_i});
          end
        end
      end
    end
    bus_ack_i = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d retirements outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    present(2'b01, 4'd4, 16'h0, 1'b1, 16'h0300, 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      valid_i = 1'b0;
      checks++;
      if ({bus_req_o, err_o, stall_req_o} !== 3'b101) begin
        errors++;
        $display("FAIL timeout_wait_%0d: got req=%b err=%b stall=%b expected 1/0/1", k, bus_req_o, err_o, stall_req_o);
      end
    end
`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    checks++;
    if ({err_o, bus_req_o, stall_req_o, we_o} !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_abort: got err=%b req=%b stall=%b we=%b expected 1/0/0/0", err_o, bus_req_o, stall_req_o, we_o);
    end
    @(negedge clk);
    checks++;
    if ({err_o, we_o} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b we=%b expected 0/0", err_o, we_o);
    end
`else
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if ({bus_req_o, err_o} !== 2'b10) begin
        errors++;
        $display("FAIL no_timeout_hold: got req=%b err=%b expected 1/0", bus_req_o, err_o);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_busy();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
